alu_op_sequencer: RTL and testbench

Shares the single-cycle-combinational ALU between two requesters: arbitrates, registers operands, and holds them stable on the ALU inputs for a per-opcode settle time. After that time it captures the result and returns it with a requester tag over a valid/ready response channel. Sits between the control-unit issue logic (requester 0) and the address/auxiliary datapath (requester 1) and the ALU's A, B, op, result ports.

---
 rtl/alu_op_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - two-requester sequencer for a shared combinational ALU
//
// Arbitrates between two requesters (round-robin on contention), registers the
// granted opcode and operands onto the ALU inputs, holds them for a per-opcode
// settle time, then captures the ALU result and offers it with a requester tag
// on a valid/ready response channel.
//
// Ports:
//   clock, clear_n              clock and asynchronous active-low reset
//   reqN_valid/ready            request handshake (N = 0, 1); ready only in IDLE
//   reqN_op, reqN_a, reqN_b     request opcode and operands
//   alu_op, alu_a, alu_b        registered ALU inputs, stable while executing
//   alu_result                  combinational ALU output
//   rsp_valid/ready             response handshake
//   rsp_id, rsp_result, rsp_err requester served, captured result, illegal-op flag
//   busy                        sequencer not idle
module alu_op_sequencer #(
    parameter int FAST_LAT = 1,
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 8
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic        busy
);

    localparam int MAX_LAT = (FAST_LAT > MUL_LAT)
                           ? ((FAST_LAT > DIV_LAT) ? FAST_LAT : DIV_LAT)
                           : ((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT);
    localparam int CNT_W = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               prio_q, prio_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        alu_a_q, alu_a_d;
    logic [31:0]        alu_b_q, alu_b_d;
    logic [3:0]         alu_op_q, alu_op_d;
    logic               rsp_id_q, rsp_id_d;
    logic [31:0]        rsp_result_q, rsp_result_d;
    logic               rsp_err_q, rsp_err_d;

    logic               grant_any;
    logic               grant_id;
    logic [3:0]         sel_op;
    logic               cur_err;

    // Opcodes 12-15 are illegal: they take one settle cycle and return 0.
    function automatic logic [CNT_W-1:0] lat_of(input logic [3:0] op);
        if (op <= 4'd9)       return CNT_W'(FAST_LAT);
        else if (op == 4'd10) return CNT_W'(MUL_LAT);
        else if (op == 4'd11) return CNT_W'(DIV_LAT);
        else                  return CNT_W'(1);
    endfunction

    // Pointer only matters when both request; a lone requester always wins.
    assign grant_any = req0_valid | req1_valid;
    assign grant_id  = (req0_valid & req1_valid) ? prio_q : req1_valid;
    assign sel_op    = grant_id ? req1_op : req0_op;
    assign cur_err   = (alu_op_q[3:2] == 2'b11);

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    alu_op_d   = sel_op;
                    alu_a_d    = grant_id ? req1_a : req0_a;
                    alu_b_d    = grant_id ? req1_b : req0_b;
                    rsp_id_d   = grant_id;
                    cnt_d      = lat_of(sel_op);
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_result_d = cur_err ? 32'd0 : alu_result;
                    rsp_err_d    = cur_err;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    prio_d  = ~rsp_id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            cnt_q        <= '0;
            alu_a_q      <= 32'd0;
            alu_b_q      <= 32'd0;
            alu_op_q     <= 4'd0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op, alu_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] alu_a, alu_b, alu_result, rsp_result;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    alu_op_sequencer #(.FAST_LAT(1), .MUL_LAT(4), .DIV_LAT(8)) dut (
        .clock(clock), .clear_n(clear_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
    );

    // ALU: and, or, neg, shr, shra, shl, ror, rol, add, sub, mul, div
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] dbl;
        logic [4:0]  s;
        s   = b[4:0];
        dbl = {a, a};
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return -a;
            4'd3:  return a >> s;
            4'd4:  return 32'($signed(a) >>> s);
            4'd5:  return a << s;
            4'd6:  begin dbl = dbl >> s; return dbl[31:0]; end
            4'd7:  begin dbl = dbl << s; return dbl[63:32]; end
            4'd8:  return a + b;
            4'd9:  return a - b;
            4'd10: return a * b;
            4'd11: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

    function automatic int ref_lat(input logic [3:0] op);
        if (op == 4'd10) return 4;
        if (op == 4'd11) return 8;
        return 1;
    endfunction

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        return (op >= 4'd12) ? 32'd0 : alu_fn(op, a, b);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_rsp_result"}, rsp_result, 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        clear_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        @(negedge clock);
        clear_n = 1'b1;
    endtask

    // Issues one op from a single requester and takes its response.
    task automatic do_op(input logic rid, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat, output logic [31:0] res,
                         output logic err, output logic id_o);
        int   waitc;
        logic rdy;
        @(negedge clock);
        if (rid) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        waitc = 0;
        rdy = rid ? req1_ready : req0_ready;
        while (!rdy && waitc < 50) begin
            @(negedge clock); #1;
            waitc++;
            rdy = rid ? req1_ready : req0_ready;
        end
        chk("accept_ready", 32'(rdy), 32'd1);
        chk("other_ready_low", 32'(rid ? req0_ready : req1_ready), 32'd0);
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_op = 4'($urandom); req0_a = $urandom; req0_b = $urandom;
        req1_op = 4'($urandom); req1_a = $urandom; req1_b = $urandom;
        #1;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            chk("alu_op_hold", 32'(alu_op), 32'(op));
            chk("alu_a_hold", alu_a, a);
            chk("alu_b_hold", alu_b, b);
            lat++;
            @(negedge clock); #1;
        end
        res  = rsp_result;
        err  = rsp_err;
        id_o = rsp_id;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        #1;
        chk("idle_after_rsp", {30'd0, busy, rsp_valid}, 32'd0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int          lat, g_idx, r_idx;
        logic [31:0] res, a, b;
        logic        err, id_o, rid, seen;
        logic [3:0]  op;

        vecs[0]  = '{4'd8,  32'd5,          32'd7,      32'd12,         1'b0, 1};
        vecs[1]  = '{4'd10, 32'd6,          32'd7,      32'd42,         1'b0, 4};
        vecs[2]  = '{4'd9,  32'd10,         32'd3,      32'd7,          1'b0, 1};
        vecs[3]  = '{4'd0,  32'h0000_F0F0,  32'h0000_FF00, 32'h0000_F000, 1'b0, 1};
        vecs[4]  = '{4'd1,  32'h0000_00F0,  32'h0000_000F, 32'h0000_00FF, 1'b0, 1};
        vecs[5]  = '{4'd2,  32'd1,          32'd0,      32'hFFFF_FFFF,  1'b0, 1};
        vecs[6]  = '{4'd3,  32'h0000_0080,  32'd3,      32'h0000_0010,  1'b0, 1};
        vecs[7]  = '{4'd4,  32'h8000_0000,  32'd4,      32'hF800_0000,  1'b0, 1};
        vecs[8]  = '{4'd5,  32'd1,          32'd4,      32'd16,         1'b0, 1};
        vecs[9]  = '{4'd6,  32'd1,          32'd1,      32'h8000_0000,  1'b0, 1};
        vecs[10] = '{4'd7,  32'h8000_0000,  32'd1,      32'd1,          1'b0, 1};
        vecs[11] = '{4'd11, 32'd100,        32'd7,      32'd14,         1'b0, 8};
        vecs[12] = '{4'd13, 32'd9,          32'd9,      32'd0,          1'b1, 1};
        vecs[13] = '{4'd15, 32'd1,          32'd2,      32'd0,          1'b1, 1};

        clear_n = 1'b0;
        req0_valid = 1'b0; req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b0; req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
        rsp_ready  = 1'b0;
        @(negedge clock); #1;
        chk_reset_values("reset");
        chk("reset_req0_ready", 32'(req0_ready), 32'd0);
        chk("reset_req1_ready", 32'(req1_ready), 32'd0);
        @(negedge clock);
        clear_n = 1'b1;

        // Directed vectors, alternating requesters (req0 add first, req1 mul second).
        for (int i = 0; i < 14; i++) begin
            rid = (i % 2) == 1;
            do_op(rid, vecs[i].op, vecs[i].a, vecs[i].b, lat, res, err, id_o);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_result", i), res, vecs[i].res);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
            chk($sformatf("vec%0d_id", i), 32'(id_o), 32'(rid));
        end

        // Random single-requester ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            rid = 1'($urandom_range(0, 1));
            op  = 4'($urandom_range(0, 15));
            a   = $urandom;
            b   = $urandom;
            do_op(rid, op, a, b, lat, res, err, id_o);
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(ref_lat(op)));
            chk($sformatf("rnd%0d_result", i), res, ref_result(op, a, b));
            chk($sformatf("rnd%0d_err", i), 32'(err), 32'(op >= 4'd12));
            chk($sformatf("rnd%0d_id", i), 32'(id_o), 32'(rid));
        end

        // Contention from reset: grants and responses must alternate 0,1,0,1...
        do_reset();
        req0_valid = 1'b1; req0_op = 4'd8; req0_a = 32'd3;  req0_b = 32'd4;
        req1_valid = 1'b1; req1_op = 4'd9; req1_a = 32'd20; req1_b = 32'd5;
        rsp_ready  = 1'b1;
        g_idx = 0;
        r_idx = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (req0_ready && req1_ready) chk("both_ready", 32'd1, 32'd0);
            if (req0_ready || req1_ready) begin
                chk($sformatf("grant%0d", g_idx), 32'(req1_ready), 32'(g_idx % 2));
                g_idx++;
            end
            if (rsp_valid) begin
                chk($sformatf("cont_rsp_id%0d", r_idx), 32'(rsp_id), 32'(r_idx % 2));
                chk($sformatf("cont_rsp_res%0d", r_idx), rsp_result,
                    (r_idx % 2) ? 32'd15 : 32'd7);
                r_idx++;
            end
            @(negedge clock);
        end
        chk("cont_grant_count", 32'(g_idx), 32'd10);
        chk("cont_rsp_count", 32'(r_idx), 32'd10);

        // Backpressure: response held in DONE, no new grants.
        do_reset();
        req1_valid = 1'b1; req1_op = 4'd8; req1_a = 32'd100; req1_b = 32'd23;
        #1;
        chk("bp_accept", 32'(req1_ready), 32'd1);
        @(negedge clock);
        req1_valid = 1'b0;
        #1;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clock); #1;
            lat++;
        end
        chk("bp_lat", 32'(lat), 32'd1);
        for (int k = 0; k < 5; k++) begin
            req0_valid = 1'b1; req0_op = 4'd8; req0_a = 32'd1; req0_b = 32'd1;
            #1;
            chk($sformatf("bp_valid%0d", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_result%0d", k), rsp_result, 32'd123);
            chk($sformatf("bp_id%0d", k), 32'(rsp_id), 32'd1);
            chk($sformatf("bp_ready%0d", k), {30'd0, req0_ready, req1_ready}, 32'd0);
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        #1;
        chk("bp_release_busy", 32'(busy), 32'd0);
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_grant", 32'(req0_ready), 32'd1);
        req0_valid = 1'b0;

        // Leave prio at 1, then reset during the 3rd EXEC cycle of a div.
        do_op(1'b0, 4'd8, 32'd2, 32'd2, lat, res, err, id_o);
        chk("pre_reset_res", res, 32'd4);
        @(negedge clock);
        req0_valid = 1'b1; req0_op = 4'd11; req0_a = 32'd1000; req0_b = 32'd10;
        #1;
        chk("div_accept", 32'(req0_ready), 32'd1);
        @(negedge clock);
        req0_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("div_busy", 32'(busy), 32'd1);
        chk("div_alu_a", alu_a, 32'd1000);
        clear_n = 1'b0;
        #1;
        chk_reset_values("midreset");
        @(negedge clock);
        clear_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock); #1;
            if (rsp_valid) seen = 1'b1;
        end
        chk("no_rsp_after_reset", 32'(seen), 32'd0);
        req0_valid = 1'b1; req0_op = 4'd8; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = 4'd8; req1_a = 32'd1; req1_b = 32'd1;
        #1;
        chk("post_reset_grant0", 32'(req0_ready), 32'd1);
        chk("post_reset_grant1", 32'(req1_ready), 32'd0);
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
